// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
//
// Purpose:
//   Watches a multiplexed, active-low 7-segment display bus and turns it back
//   into a 4-digit frame. A digit is accepted after its selection and segment
//   pattern have stayed identical for STABLE_CYCLES consecutive cycles. Once all
//   four digits are captured, the frame is presented on a valid/ready port.
//
// Optional feature (macro SEG_DP_EN):
//   When defined, seg carries the decimal point on bit 7 (active low). The
//   inverted dp is captured per digit into dp_out. dp takes part in the
//   stability comparison but not in the decode or the err flag.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   seg          in   active-low segments, bit0=a .. bit6=g (bit7=dp with SEG_DP_EN)
//   dig_sel      in   active-low digit select, bit i selects digit i
//   value        out  presented frame, digit i in bits [4i+3:4i]
//   err          out  per-digit invalid-pattern flag of the presented frame
//   dp_out       out  per-digit decimal point, 1 = lit (SEG_DP_EN only)
//   valid        out  frame available
//   ready        in   consumer accepts the frame
//   overrun      out  sticky: a completed frame was dropped while presenting
//   dbg_state_o  out  FSM state (0 = COLLECT, 1 = PRESENT)
//
// Handshake: valid rises the cycle after a frame completes and then holds,
// with value/err/dp_out stable, until a cycle where valid and ready are both
// 1; valid is 0 from the following cycle. ready is ignored while valid is 0.
// -----------------------------------------------------------------------------
module seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SEG_DP_EN
  input  logic [7:0]  seg,
`else
  input  logic [6:0]  seg,
`endif
  input  logic [3:0]  dig_sel,
  output logic [15:0] value,
  output logic [3:0]  err,
`ifdef SEG_DP_EN
  output logic [3:0]  dp_out,
`endif
  output logic        valid,
  input  logic        ready,
  output logic        overrun,
  output logic        dbg_state_o
);

`ifdef SEG_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  localparam logic [7:0] STABLE_M1  = 8'(STABLE_CYCLES - 1);
  localparam logic       ONE_CYCLE  = (STABLE_CYCLES == 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  state_e             state_q;
  logic [SEG_W-1:0]   seg_prev_q;
  logic [3:0]         sel_prev_q;
  logic [7:0]         cnt_q, cnt_d;
  logic [3:0]         captured_q, captured_d;
  logic [15:0]        work_val_q;
  logic [3:0]         work_err_q;
`ifdef SEG_DP_EN
  logic [3:0]         work_dp_q;
`endif

  logic               sel_legal;
  logic [1:0]         dig_idx;
  logic               blank;
  logic               same;
  logic               accept;
  logic               capture;
  logic               frame_done;
  logic [4:0]         dec;

  // Returns {invalid, nibble}; an unknown pattern yields nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = 5'h00;
      7'b1111001: r = 5'h01;
      7'b0100100: r = 5'h02;
      7'b0110000: r = 5'h03;
      7'b0011001: r = 5'h04;
      7'b0010010: r = 5'h05;
      7'b0000010: r = 5'h06;
      7'b1111000: r = 5'h07;
      7'b0000000: r = 5'h08;
      7'b0010000: r = 5'h09;
      7'b0001000: r = 5'h0A;
      7'b0000011: r = 5'h0B;
      7'b1000110: r = 5'h0C;
      7'b0100001: r = 5'h0D;
      7'b0000110: r = 5'h0E;
      7'b0001110: r = 5'h0F;
      default:    r = 5'h10;
    endcase
    return r;
  endfunction

  always_comb begin
    sel_legal = 1'b0;
    dig_idx   = 2'd0;
    case (dig_sel)
      4'b1110: begin sel_legal = 1'b1; dig_idx = 2'd0; end
      4'b1101: begin sel_legal = 1'b1; dig_idx = 2'd1; end
      4'b1011: begin sel_legal = 1'b1; dig_idx = 2'd2; end
      4'b0111: begin sel_legal = 1'b1; dig_idx = 2'd3; end
      default: begin sel_legal = 1'b0; dig_idx = 2'd0; end
    endcase
  end

  // A blank digit or an illegal selection both break the stable run.
  assign blank  = (seg[6:0] == 7'h7F);
  assign same   = (seg == seg_prev_q) && (dig_sel == sel_prev_q);
  assign accept = sel_legal && !blank;
  assign dec    = decode(seg[6:0]);

  always_comb begin
    cnt_d   = 8'd0;
    capture = 1'b0;
    if (accept) begin
      if (same) begin
        cnt_d   = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        // Fires only on the step into STABLE_CYCLES, so a saturated
        // counter never re-captures the same run.
        capture = (cnt_q == STABLE_M1);
      end else begin
        cnt_d   = 8'd1;
        capture = ONE_CYCLE;
      end
    end
  end

  assign frame_done = (captured_q == 4'hF);

  // The completed set clears the cycle after completion; a capture in that
  // same cycle already belongs to the next frame.
  always_comb begin
    captured_d = frame_done ? 4'h0 : captured_q;
    if (capture) captured_d[dig_idx] = 1'b1;
  end

  // Stability tracking and working slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_prev_q <= '1;
      sel_prev_q <= 4'hF;
      cnt_q      <= 8'd0;
      captured_q <= 4'h0;
      work_val_q <= 16'h0;
      work_err_q <= 4'h0;
`ifdef SEG_DP_EN
      work_dp_q  <= 4'h0;
`endif
    end else begin
      seg_prev_q <= seg;
      sel_prev_q <= dig_sel;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      if (capture) begin
        work_val_q[{dig_idx, 2'b00} +: 4] <= dec[3:0];
        work_err_q[dig_idx]               <= dec[4];
`ifdef SEG_DP_EN
        work_dp_q[dig_idx]                <= ~seg[7];
`endif
      end
    end
  end

  // Frame presentation FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      value   <= 16'h0;
      err     <= 4'h0;
`ifdef SEG_DP_EN
      dp_out  <= 4'h0;
`endif
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (frame_done) begin
            value   <= work_val_q;
            err     <= work_err_q;
`ifdef SEG_DP_EN
            dp_out  <= work_dp_q;
`endif
            valid   <= 1'b1;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // Collection keeps running; a frame finishing now has nowhere to go.
          if (frame_done) overrun <= 1'b1;
          if (ready) begin
            valid   <= 1'b0;
            state_q <= ST_COLLECT;
          end
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_capture.sv
module tb_seg_capture;
  localparam int S = 4;
`ifdef SEG_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SEG_W-1:0] seg = '1;
  logic [3:0]       dig_sel = 4'hF;
  logic [15:0]      value;
  logic [3:0]       err;
  logic             valid;
  logic             ready = 1'b0;
  logic             overrun;
  logic             dbg_state;
`ifdef SEG_DP_EN
  logic [3:0]       dp_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .dig_sel     (dig_sel),
    .value       (value),
    .err         (err),
`ifdef SEG_DP_EN
    .dp_out      (dp_out),
`endif
    .valid       (valid),
    .ready       (ready),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  logic [6:0] pat_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- reference model (run level) ----------------
  // Expected frame packing: {dp[3:0], err[3:0], value[15:0]}
  logic [23:0]      exp_q[$];
  logic [3:0]       m_val [4];
  logic             m_err [4];
  logic             m_dp  [4];
  logic [3:0]       m_set = 4'h0;
  bit               m_prev_ok = 0;
  logic [3:0]       m_prev_sel = 4'hF;
  logic [SEG_W-1:0] m_prev_seg = '1;
  int               m_run_total = 0;
  bit               m_drop = 0;

  function automatic logic [23:0] model_frame();
    logic [23:0] f;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      f[4*i +: 4] = m_val[i];
      f[16 + i]   = m_err[i];
      f[20 + i]   = m_dp[i];
    end
    return f;
  endfunction

  task automatic model_reset();
    m_set = 4'h0;
    m_prev_ok = 0;
    m_run_total = 0;
  endtask

  // Applies one run: the same selection and pattern held for len cycles.
  task automatic model_run(input logic [3:0] sel, input logic [SEG_W-1:0] s, input int len);
    int n, idx, total, nib;
    bit found;
    n = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!sel[i]) begin n++; idx = i; end
    if (n != 1 || s[6:0] == 7'h7F) begin
      m_prev_ok = 0;
    end else begin
      if (m_prev_ok && sel == m_prev_sel && s == m_prev_seg) total = m_run_total + len;
      else begin m_run_total = 0; total = len; end
      if (m_run_total < S && total >= S) begin
        found = 0; nib = 0;
        for (int v = 0; v < 16; v++) if (pat_tab[v] == s[6:0]) begin found = 1; nib = v; end
        m_val[idx] = found ? nib[3:0] : 4'h0;
        m_err[idx] = !found;
`ifdef SEG_DP_EN
        m_dp[idx]  = ~s[7];
`else
        m_dp[idx]  = 1'b0;
`endif
        m_set[idx] = 1'b1;
        if (m_set == 4'hF) begin
          m_set = 4'h0;
          if (!m_drop) exp_q.push_back(model_frame());
        end
      end
      m_run_total = total;
      m_prev_ok = 1;
      m_prev_sel = sel;
      m_prev_seg = s;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int          frames_seen = 0;
  logic [15:0] last_val = '0;
  logic [3:0]  last_err = '0;
  logic [3:0]  last_dp = '0;
  logic [23:0] mon_e;
  logic [3:0]  mon_dp;

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
`ifdef SEG_DP_EN
      mon_dp = dp_out;
`else
      mon_dp = 4'h0;
`endif
      checks++;
      frames_seen++;
      last_val = value;
      last_err = err;
      last_dp  = mon_dp;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected: got value=%h err=%b, required no frame", value, err);
      end else begin
        mon_e = exp_q.pop_front();
        if (value !== mon_e[15:0] || err !== mon_e[19:16] || mon_dp !== mon_e[23:20]) begin
          errors++;
          $display("FAIL frame_content: got value=%h err=%b dp=%b, required value=%h err=%b dp=%b",
                   value, err, mon_dp, mon_e[15:0], mon_e[19:16], mon_e[23:20]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] sel, input logic [SEG_W-1:0] s, input int len);
    dig_sel = sel;
    seg = s;
    model_run(sel, s, len);
    repeat (len) step();
  endtask

  function automatic logic [SEG_W-1:0] mk_raw(input logic [6:0] p);
    logic [SEG_W-1:0] r;
    r = '1;
    r[6:0] = p;
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] mk(input int v);
    return mk_raw(pat_tab[v]);
  endfunction

  function automatic logic [3:0] sel_of(input int i);
    logic [3:0] r;
    r = 4'hF;
    r[i] = 1'b0;
    return r;
  endfunction

  task automatic idle(input int n);
    drive(4'hF, '1, n);
  endtask

  task automatic check_drained(input string name);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d frames still pending, required 0", name, exp_q.size());
    end
    step();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string name);
    dig_sel = 4'hF;
    seg = '1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (value !== 16'h0 || err !== 4'h0 || valid !== 1'b0 || overrun !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL %s_async_clear: got value=%h err=%b valid=%b overrun=%b state=%b, required all 0",
               name, value, err, valid, overrun, dbg_state);
    end
    rst_n = 1'b1;
    model_reset();
    m_prev_ok = 0;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (value !== 16'h0) begin errors++; $display("FAIL reset_value: got %h, required 0000", value); end
    checks++; if (err !== 4'h0) begin errors++; $display("FAIL reset_err: got %b, required 0000", err); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b, required 0", dbg_state); end
`ifdef SEG_DP_EN
    checks++; if (dp_out !== 4'h0) begin errors++; $display("FAIL reset_dp: got %b, required 0000", dp_out); end
`endif
    step();
    rst_n = 1'b1;
    ready = 1'b1;
    // ready has no effect with nothing collected
    idle(6);
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b, required 0", valid); end
    step();
  endtask

  task automatic test_basic();
    int f0;
    f0 = frames_seen;
    drive(sel_of(0), mk(3), 4);
    drive(sel_of(1), mk(10), 4);
    drive(sel_of(2), mk(0), 4);
    drive(sel_of(3), mk(15), 4);
    idle(3);
    check_drained("basic");
    checks++;
    if (frames_seen != f0 + 1 || last_val !== 16'hF0A3 || last_err !== 4'h0) begin
      errors++;
      $display("FAIL basic_frame: got frames=%0d value=%h err=%b, required frames=%0d value=f0a3 err=0000",
               frames_seen - f0, last_val, last_err, 1);
    end
  endtask

  task automatic test_short_hold();
    int f0;
    f0 = frames_seen;
    drive(sel_of(0), mk(5), 4);
    drive(sel_of(1), mk(6), 3);
    drive(sel_of(2), mk(7), 4);
    drive(sel_of(3), mk(8), 4);
    idle(4);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || frames_seen != f0) begin
      errors++;
      $display("FAIL short_hold_novalid: got valid=%b frames=%0d, required valid=0 frames=0", valid, frames_seen - f0);
    end
    step();
    drive(sel_of(1), mk(9), 4);
    idle(3);
    check_drained("short_hold");
    checks++;
    if (frames_seen != f0 + 1 || last_val !== 16'h8795) begin
      errors++;
      $display("FAIL short_hold_frame: got frames=%0d value=%h, required frames=1 value=8795", frames_seen - f0, last_val);
    end
  endtask

  task automatic test_invalid();
    drive(sel_of(0), mk(1), 4);
    drive(sel_of(1), mk(2), 4);
    drive(sel_of(2), mk_raw(7'b1010101), 5);
    drive(sel_of(3), mk(4), 4);
    idle(3);
    check_drained("invalid");
    checks++;
    if (last_err !== 4'b0100 || last_val !== 16'h4021) begin
      errors++;
      $display("FAIL invalid_err: got value=%h err=%b, required value=4021 err=0100", last_val, last_err);
    end
  endtask

`ifdef SEG_DP_EN
  task automatic test_dp();
    drive(sel_of(0), 8'h40, 4);
    drive(sel_of(1), mk(1), 4);
    drive(sel_of(2), mk(2), 4);
    drive(sel_of(3), mk(3), 4);
    idle(3);
    check_drained("dp");
    checks++;
    if (last_dp !== 4'b0001 || last_val[3:0] !== 4'h0 || last_err !== 4'h0) begin
      errors++;
      $display("FAIL dp_capture: got dp=%b nib0=%h err=%b, required dp=0001 nib0=0 err=0000",
               last_dp, last_val[3:0], last_err);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0]       sel;
    logic [SEG_W-1:0] s;
    int               r, len;
    sel = 4'hF;
    s = '1;
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 9);
      if (r == 9 && k > 0) begin
        // repeat the previous run so it merges into one longer run
      end else begin
        if ($urandom_range(0, 9) == 0) sel = 4'($urandom_range(0, 15));
        else sel = sel_of($urandom_range(0, 3));
        if (r < 6)      s = mk($urandom_range(0, 15));
        else if (r < 8) s = mk_raw(7'($urandom_range(0, 127)));
        else            s = mk_raw(7'h7F);
`ifdef SEG_DP_EN
        s[7] = 1'($urandom_range(0, 1));
`endif
      end
      len = $urandom_range(1, 7);
      drive(sel, s, len);
    end
    idle(4);
    check_drained("random");
    pulse_reset("random");
  endtask

  task automatic test_overrun();
    int f0;
    f0 = frames_seen;
    ready = 1'b0;
    drive(sel_of(0), mk(1), 4);
    drive(sel_of(1), mk(2), 4);
    drive(sel_of(2), mk(3), 4);
    drive(sel_of(3), mk(4), 4);
    idle(3);
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || dbg_state !== 1'b1 || value !== 16'h4321 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_first: got valid=%b state=%b value=%h overrun=%b, required 1 1 4321 0",
               valid, dbg_state, value, overrun);
    end
    step();
    m_drop = 1;
    drive(sel_of(0), mk(6), 4);
    drive(sel_of(1), mk(7), 4);
    drive(sel_of(2), mk(8), 4);
    drive(sel_of(3), mk(9), 4);
    idle(3);
    m_drop = 0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || value !== 16'h4321 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b value=%h overrun=%b, required valid=1 value=4321 overrun=1",
               valid, value, overrun);
    end
    step();
    ready = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || dbg_state !== 1'b0 || frames_seen != f0 + 1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_release: got valid=%b state=%b frames=%0d overrun=%b, required 0 0 1 1",
               valid, dbg_state, frames_seen - f0, overrun);
    end
    step();
    check_drained("overrun");
  endtask

  task automatic test_blank_illegal();
    int f0;
    f0 = frames_seen;
    drive(4'b0011, mk(0), 10);
    drive(4'b1111, mk(1), 6);
    drive(sel_of(0), mk_raw(7'h7F), 10);
    drive(sel_of(0), mk(2), 4);
    drive(sel_of(1), mk_raw(7'h7F), 10);
    drive(sel_of(2), mk(3), 4);
    drive(sel_of(3), mk(4), 4);
    idle(4);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || frames_seen != f0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL blank_illegal: got valid=%b frames=%0d overrun=%b, required valid=0 frames=0 overrun=1",
               valid, frames_seen - f0, overrun);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int f0;
    // digits 0, 2, 3 are already captured; reset throws them away
    pulse_reset("reset_mid");
    f0 = frames_seen;
    drive(sel_of(1), mk(5), 4);
    idle(4);
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || frames_seen != f0) begin
      errors++;
      $display("FAIL reset_mid_partial: got valid=%b frames=%0d, required valid=0 frames=0", valid, frames_seen - f0);
    end
    step();
    drive(sel_of(0), mk(12), 4);
    drive(sel_of(2), mk(13), 4);
    drive(sel_of(3), mk(14), 4);
    idle(3);
    check_drained("reset_mid");
    checks++;
    if (frames_seen != f0 + 1 || last_val !== 16'hED5C || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_frame: got frames=%0d value=%h overrun=%b, required frames=1 value=ed5c overrun=0",
               frames_seen - f0, last_val, overrun);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0;
      m_err[i] = 1'b0;
      m_dp[i]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_short_hold();
    test_invalid();
`ifdef SEG_DP_EN
    test_dp();
`endif
    test_random();
    test_overrun();
    test_blank_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: the number of consecutive identical cycles needed to accept a digit (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port seg, input, 7 bits (8 bits with SEG_DP_EN): active-low segment pattern, bit0=a … bit6=g, bit7=dp.
REQ-005 SHALL have port dig_sel, input, 4 bits: active-low digit enable, where bit i selects digit i.
REQ-006 SHALL have port value, output, 16 bits: captured frame, with digit i in bits [4i+3:4i].
REQ-007 SHALL have port err, output, 4 bits: per-digit flag for an invalid-pattern capture in the presented frame.
REQ-008 SHALL have port dp_out, output, 4 bits (only with SEG_DP_EN): per-digit decimal point, 1 = lit.
REQ-009 SHALL have port valid, output, 1 bit: frame available.
REQ-010 SHALL have port ready, input, 1 bit: consumer accepts the frame.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag meaning a frame was dropped while presenting.

Function
REQ-012 SHALL treat the selection as legal only when exactly one dig_sel bit is 0; zero or several low bits SHALL clear the stability counter.
REQ-013 SHALL track a stability counter: if the legal selection and seg both equal their values from the previous cycle, the counter increments (saturating); otherwise it reloads 1.
REQ-014 SHALL capture the digit on the cycle the counter reaches STABLE_CYCLES; only one capture per stable run, with no re-capture until seg or dig_sel changes.
REQ-015 SHALL NOT capture the blank pattern 7'b1111111; it counts as instability.
REQ-016 SHALL decode seg[6:0] into values 0..F using 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-017 SHALL store nibble 0 and set the working err bit for any other non-blank pattern.
REQ-018 SHALL record each capture in a working slot and set captured[i]; a re-capture of the same digit before the frame completes overwrites the slot.
REQ-019 SHALL complete a frame when captured==4'b1111; the cycle after completion, captured clears and the working registers feed the frame transfer.
REQ-020 SHALL implement FSM COLLECT: on frame completion, load value/err/dp_out and go to PRESENT, with valid=1 from the next cycle.
REQ-021 SHALL implement FSM PRESENT: valid held 1 and outputs stable; valid&ready returns the FSM to COLLECT next cycle with valid=0.
REQ-022 SHALL continue collection in PRESENT; a frame completing in PRESENT (including on the ready cycle) SHALL be discarded and SHALL set overrun.
REQ-023 SHALL clear overrun only by reset.
REQ-024 SHALL give ready no effect in COLLECT.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear value=0, err=0, dp_out=0, valid=0, overrun=0, captured=0 and the counter=0, and put the FSM in COLLECT.
REQ-026 SHALL discard a partially collected frame on reset; after release, collection restarts from an empty captured set.

Configuration
REQ-027 SHALL, when macro SEG_DP_EN is defined, make seg 8 bits and capture bit7 inverted into dp_out[i] with the digit; dp SHALL take part in the stability comparison but SHALL NOT affect decode or err.
REQ-028 SHALL, when SEG_DP_EN is undefined, make seg 7 bits and omit dp_out.

Verification
REQ-029 SHALL pass scenario: digits 0..3 driven with 3,A,0,F, each held 4 cycles -> valid=1 with value=16'hF0A3 and err=0.
REQ-030 SHALL pass scenario: digit 1 held only 3 cycles in a 4-digit scan -> no valid until digit 1 is held 4 cycles.
REQ-031 SHALL pass scenario: digit 2 pattern 1010101 -> frame err=4'b0100 with nibble 2 = 0.
REQ-032 SHALL pass scenario: ready=0 while a second full frame is captured -> value unchanged and overrun=1; after ready=1, valid falls next cycle.
REQ-033 SHALL pass scenario: dig_sel=4'b0011 or the blank pattern -> no capture; rst_n pulsed mid-frame -> outputs are zero and the next frame needs all 4 digits again.
REQ-034 SHALL pass scenario (SEG_DP_EN): digit 0 with seg=8'h40 (dp lit, pattern 0) -> dp_out[0]=1 and nibble 0 = 0.
